change_dispenser: RTL and testbench

Pays out the change owed by the vending machine FSM, one coin at a time, to an external coin-hopper mechanism.
- Captures the vending machine's `change` amount on its vend strobe.
- Greedily ejects big coins while the big-coin hopper has stock, then small coins.
- Handshakes each coin with the mechanism's drop acknowledge.
- Sits between the vending machine core and the hopper driver board.

---
 rtl/change_dispenser_if.sv | 27 ++
 rtl/change_dispenser.sv | 152 +++++++++++++++
 tb/tb_change_dispenser.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Bundle of vending-core / coin-hopper signals for change_dispenser.
// The master side is the vending core plus hopper board; the slave side is the dispenser.
interface change_dispenser_if #(
    parameter int WIDTH = 3
);
    logic             vend;
    logic [WIDTH-1:0] change;
    logic             refill;
    logic             coin_ack;
    logic             eject_big;
    logic             eject_small;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] remaining;
    logic [3:0]       big_left;
    logic             fault;

    modport master (
        output vend, change, refill, coin_ack,
        input  eject_big, eject_small, busy, done, remaining, big_left, fault
    );

    modport slave (
        input  vend, change, refill, coin_ack,
        output eject_big, eject_small, busy, done, remaining, big_left, fault
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout engine: big coins while stocked, then small coins, one ack per coin.
// Optional ack-timeout fault is enabled by defining CHANGE_DISP_TIMEOUT_EN.
module change_dispenser #(
    parameter int WIDTH        = 3,
    parameter int BIG_VAL      = 2,
    parameter int HOPPER_DEPTH = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 15
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_PULSE    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
`ifdef CHANGE_DISP_TIMEOUT_EN
    localparam logic [2:0] S_FAULT    = 3'd5;
    localparam int         TW         = $clog2(ACK_TIMEOUT + 1);
`endif
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    logic [2:0]       state_r;
    logic             sel_big_r;
    logic [PW-1:0]    pulse_cnt_r;
    logic             eject_big_r;
    logic             eject_small_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] remaining_r;
    logic [3:0]       big_left_r;
    logic [WIDTH-1:0] coin_val_s;
    logic [WIDTH-1:0] rem_next_s;
    logic             take_big_s;
`ifdef CHANGE_DISP_TIMEOUT_EN
    logic [TW-1:0]    to_cnt_r;
    logic             fault_r;
`endif

    // A big coin is only picked when it cannot overshoot the amount owed
    assign coin_val_s = sel_big_r ? WIDTH'(BIG_VAL) : WIDTH'(1);
    assign rem_next_s = remaining_r - coin_val_s;
    assign take_big_s = (remaining_r >= WIDTH'(BIG_VAL)) && (big_left_r != 4'd0);

    // Payout sequencer and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            sel_big_r     <= 1'b0;
            pulse_cnt_r   <= PW'(0);
            eject_big_r   <= 1'b0;
            eject_small_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            remaining_r   <= WIDTH'(0);
            big_left_r    <= 4'(HOPPER_DEPTH);
`ifdef CHANGE_DISP_TIMEOUT_EN
            to_cnt_r      <= TW'(0);
            fault_r       <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.vend) begin
                        if (bus.change != WIDTH'(0)) begin
                            remaining_r <= bus.change;
                            busy_r      <= 1'b1;
                            state_r     <= S_SELECT;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end else if (bus.refill) begin
                        big_left_r <= 4'(HOPPER_DEPTH);
                    end
                end
                S_SELECT: begin
                    sel_big_r     <= take_big_s;
                    eject_big_r   <= take_big_s;
                    eject_small_r <= ~take_big_s;
                    pulse_cnt_r   <= PW'(0);
                    state_r       <= S_PULSE;
                end
                S_PULSE: begin
                    if (pulse_cnt_r == PW'(PULSE_CYCLES - 1)) begin
                        eject_big_r   <= 1'b0;
                        eject_small_r <= 1'b0;
`ifdef CHANGE_DISP_TIMEOUT_EN
                        to_cnt_r      <= TW'(0);
`endif
                        state_r       <= S_WAIT_ACK;
                    end else begin
                        pulse_cnt_r <= pulse_cnt_r + PW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (bus.coin_ack) begin
                        remaining_r <= rem_next_s;
                        if (sel_big_r && (big_left_r != 4'd0)) begin
                            big_left_r <= big_left_r - 4'd1;
                        end
                        if (rem_next_s == WIDTH'(0)) begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            state_r <= S_SELECT;
                        end
`ifdef CHANGE_DISP_TIMEOUT_EN
                    end else if (to_cnt_r == TW'(ACK_TIMEOUT - 1)) begin
                        fault_r <= 1'b1;
                        state_r <= S_FAULT;
                    end else begin
                        to_cnt_r <= to_cnt_r + TW'(1);
`endif
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
`ifdef CHANGE_DISP_TIMEOUT_EN
                // Latched until rst: remaining stays frozen and nothing is ejected
                S_FAULT: begin
                    fault_r <= 1'b1;
                    busy_r  <= 1'b1;
                end
`endif
                default: begin
                    eject_big_r   <= 1'b0;
                    eject_small_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.eject_big   = eject_big_r;
    assign bus.eject_small = eject_small_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.remaining   = remaining_r;
    assign bus.big_left    = big_left_r;
`ifdef CHANGE_DISP_TIMEOUT_EN
    assign bus.fault       = fault_r;
`else
    assign bus.fault       = 1'b0;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// Table-driven bench for change_dispenser with a per-coin expectation queue.
module tb_change_dispenser;
    localparam int WIDTH = 3;
    localparam int PULSE = 2;
    localparam int DEPTH = 8;
    localparam int TMO   = 15;

    typedef struct {
        logic [2:0] change;
        bit         refill;
        int         ack_delay;
        bit         early_ack;
        bit         second_vend;
        int         exp_big;
        int         exp_small;
        logic [3:0] exp_bl;
    } vec_t;

    typedef struct {
        bit         big;
        logic [2:0] rem;
        logic [3:0] bl;
    } coin_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    coin_t exp_q[$];
    logic [3:0] m_bl;
    vec_t vecs[9];

    always #5 clk = ~clk;

    change_dispenser_if #(.WIDTH(WIDTH)) bus ();

    change_dispenser #(
        .WIDTH(WIDTH), .BIG_VAL(2), .HOPPER_DEPTH(DEPTH),
        .PULSE_CYCLES(PULSE), .ACK_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Greedy reference: big coin when owed >= 2 and stock remains, else small
    task automatic model_push(input logic [2:0] c);
        logic [2:0] r;
        coin_t e;
        r = c;
        while (r != 3'd0) begin
            if (r >= 3'd2 && m_bl != 4'd0) begin
                e.big = 1'b1; r = r - 3'd2; m_bl = m_bl - 4'd1;
            end else begin
                e.big = 1'b0; r = r - 3'd1;
            end
            e.rem = r;
            e.bl  = m_bl;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_refill();
        @(negedge clk); bus.refill = 1'b1;
        @(negedge clk); bus.refill = 1'b0;
        chk("refill_big_left", bus.big_left, DEPTH);
        m_bl = 4'(DEPTH);
    endtask

    task automatic run_payout(input int idx, input vec_t v);
        int hi = 0, ack_wait = 0, nb = 0, ns = 0, dones = 0, done_cyc = -1;
        bit waiting = 0, pending = 0, finished = 0, busy_bad = 0, both_bad = 0, cur_big = 0;
        coin_t e;
        if (v.refill) do_refill();
        model_push(v.change);
        @(negedge clk); bus.vend = 1'b1; bus.change = v.change;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            bus.vend = 1'b0;
            bus.coin_ack = 1'b0;
            if (pending) begin
                pending = 0;
                if (exp_q.size() == 0) begin
                    chk($sformatf("v%0d_queue_underrun", idx), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("v%0d_remaining", idx), bus.remaining, e.rem);
                    chk($sformatf("v%0d_big_left", idx), bus.big_left, e.bl);
                end
            end
            if (bus.eject_big && bus.eject_small) both_bad = 1;
            if (bus.eject_big || bus.eject_small) begin
                hi++;
                cur_big = bus.eject_big;
                if (v.early_ack && hi == 1) bus.coin_ack = 1'b1;
                if (v.second_vend && hi == 1 && nb + ns == 0) begin
                    bus.vend = 1'b1; bus.change = 3'd2;
                end
            end else if (hi != 0) begin
                chk($sformatf("v%0d_pulse_len", idx), hi, PULSE);
                if (exp_q.size() == 0) chk($sformatf("v%0d_extra_coin", idx), 1, 0);
                else chk($sformatf("v%0d_coin_type", idx), cur_big, exp_q[0].big);
                if (cur_big) nb++; else ns++;
                hi = 0; waiting = 1; ack_wait = v.ack_delay;
            end
            if (waiting) begin
                if (ack_wait == 0) begin
                    bus.coin_ack = 1'b1; waiting = 0; pending = 1;
                end else begin
                    ack_wait--;
                end
            end
            if ((v.change != 3'd0) != bus.busy) busy_bad = 1;
            if (bus.done) begin
                dones++; finished = 1; done_cyc = cyc;
            end
        end
        chk($sformatf("v%0d_completed", idx), finished, 1);
        if (v.change == 3'd0) chk($sformatf("v%0d_done_latency", idx), done_cyc, 0);
        chk($sformatf("v%0d_big_coins", idx), nb, v.exp_big);
        chk($sformatf("v%0d_small_coins", idx), ns, v.exp_small);
        chk($sformatf("v%0d_busy_profile", idx), busy_bad, 0);
        chk($sformatf("v%0d_both_ejects", idx), both_bad, 0);
        chk($sformatf("v%0d_queue_left", idx), exp_q.size(), 0);
        chk($sformatf("v%0d_final_big_left", idx), bus.big_left, v.exp_bl);
        chk($sformatf("v%0d_fault", idx), bus.fault, 0);
        exp_q.delete();
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse_end", idx), bus.done, 0);
        chk($sformatf("v%0d_busy_after", idx), bus.busy, 0);
    endtask

    initial begin
        bit seen, stray;
        // change, refill, ack_delay, early_ack, second_vend, big, small, big_left
        vecs[0] = '{3'd3, 1'b0, 0, 1'b0, 1'b0, 1, 1, 4'd7};
        vecs[1] = '{3'd0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 4'd7};
        vecs[2] = '{3'd4, 1'b1, 2, 1'b1, 1'b1, 2, 0, 4'd6};
        vecs[3] = '{3'd7, 1'b0, 1, 1'b0, 1'b0, 3, 1, 4'd3};
        vecs[4] = '{3'd7, 1'b0, 0, 1'b0, 1'b0, 3, 1, 4'd0};
        vecs[5] = '{3'd5, 1'b0, 3, 1'b0, 1'b0, 0, 5, 4'd0};
        vecs[6] = '{3'd2, 1'b1, 0, 1'b0, 1'b0, 1, 0, 4'd7};
        vecs[7] = '{3'd1, 1'b0, 0, 1'b0, 1'b0, 0, 1, 4'd7};
        vecs[8] = '{3'd6, 1'b0, 1, 1'b0, 1'b0, 3, 0, 4'd4};

        rst = 1'b1;
        bus.vend = 1'b0; bus.change = 3'd0; bus.refill = 1'b0; bus.coin_ack = 1'b0;
        m_bl = 4'(DEPTH);
        @(negedge clk); @(negedge clk);
        chk("rst_eject_big", bus.eject_big, 0);
        chk("rst_eject_small", bus.eject_small, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_remaining", bus.remaining, 0);
        chk("rst_big_left", bus.big_left, DEPTH);
        chk("rst_fault", bus.fault, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_payout(i, vecs[i]);

        // Reset during the first pulse of change=6 abandons the payout
        @(negedge clk); bus.vend = 1'b1; bus.change = 3'd6;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); bus.vend = 1'b0;
            if (bus.eject_big || bus.eject_small) seen = 1;
        end
        chk("rstpulse_eject_seen", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstpulse_eject_big", bus.eject_big, 0);
        chk("rstpulse_eject_small", bus.eject_small, 0);
        chk("rstpulse_busy", bus.busy, 0);
        chk("rstpulse_done", bus.done, 0);
        chk("rstpulse_remaining", bus.remaining, 0);
        chk("rstpulse_big_left", bus.big_left, DEPTH);
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.eject_big || bus.eject_small || bus.busy) stray = 1;
        end
        chk("rstpulse_no_resume", stray, 0);
        m_bl = 4'(DEPTH);

`ifdef CHANGE_DISP_TIMEOUT_EN
        // change=1 with no ack: fault rises ACK_TIMEOUT cycles into WAIT_ACK
        @(negedge clk); bus.vend = 1'b1; bus.change = 3'd1;
        seen = 0; stray = 0;
        for (int c = 0; c < 10 && !stray; c++) begin
            @(negedge clk); bus.vend = 1'b0;
            if (bus.eject_small) seen = 1;
            else if (seen) stray = 1;
        end
        chk("tmo_pulse_end_seen", stray, 1);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            if (k == TMO - 1) chk("tmo_fault_early", bus.fault, 0);
        end
        chk("tmo_fault", bus.fault, 1);
        chk("tmo_remaining", bus.remaining, 1);
        chk("tmo_busy", bus.busy, 1);
        @(negedge clk);
        chk("tmo_no_eject", bus.eject_big | bus.eject_small, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("tmo_fault_cleared", bus.fault, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
